// File: rtl/key_device_pkg.sv
`default_nettype none
//---- key_device_pkg : register map and key count shared by the key input device ----
//---- rev 1.0 ------------------------------------------------------------------------
package key_device_pkg;

  localparam int          NKEYS       = 4;
  localparam logic [31:0] KDATA_OFF   = 32'd0;
  localparam logic [31:0] KCTRL_OFF   = 32'd4;
  localparam int          READY_BIT   = 0;
  localparam int          OVERRUN_BIT = 2;
  localparam int          IE_BIT      = 8;

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
//---- key_debouncer : 2-flop synchroniser, polarity flip and stability counter per key ----
//---- rev 1.0 ------------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEB_CYC = 10000
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw_n,
  output logic state,
  output logic changed
);

  localparam int CW = $clog2(DEB_CYC);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic          state_q, state_d;
  logic          changed_q, changed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sampled;

  always_comb begin
    sync0_d   = raw_n;
    sync1_d   = sync0_q;
    sampled   = ~sync1_q;
    state_d   = state_q;
    changed_d = 1'b0;
    cnt_d     = '0;
    // The accepting edge is the one on which the count would reach DEB_CYC-1.
    if (sampled != state_q) begin
      if (cnt_q == CW'(DEB_CYC - 2)) begin
        state_d   = sampled;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync0_q   <= 1'b1;
      sync1_q   <= 1'b1;
      state_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      state_q   <= state_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state   = state_q;
  assign changed = changed_q;

endmodule
`default_nettype wire

// File: rtl/key_device.sv
`default_nettype none
//---- key_device : memory-mapped debounced push-button port with ready/overrun/IRQ ----
//---- rev 1.0 ----------------------------------------------------------------------
module key_device
  import key_device_pkg::*;
#(
  parameter int              BITS    = 32,
  parameter logic [BITS-1:0] BASE    = 32'hF0000010,
  parameter int              DEB_CYC = 10000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [BITS-1:0]  ABUS,
  inout  wire  [BITS-1:0]  DBUS,
  input  logic             WE,
  input  logic [NKEYS-1:0] KEY,
  output logic             INTR
);

  localparam logic [BITS-1:0] ADDR_DATA = BASE + BITS'(KDATA_OFF);
  localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(KCTRL_OFF);

  logic [NKEYS-1:0] key_state;
  logic [NKEYS-1:0] key_changed;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debouncer #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .CLK     (CLK),
      .reset   (reset),
      .raw_n   (KEY[i]),
      .state   (key_state[i]),
      .changed (key_changed[i])
    );
  end

  logic [NKEYS-1:0] kdata_q, kdata_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ie_q, ie_d;
  logic             rd_data, rd_ctrl, wr_ctrl, key_event;
  logic [BITS-1:0]  data_word, ctrl_word;

  always_comb begin
    rd_data   = !WE && (ABUS == ADDR_DATA);
    rd_ctrl   = !WE && (ABUS == ADDR_CTRL);
    wr_ctrl   = WE && (ABUS == ADDR_CTRL);
    key_event = |key_changed;

    kdata_d   = key_event ? key_state : kdata_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ie_d      = ie_q;

    if (rd_data) ready_d = 1'b0;
    if (wr_ctrl && !DBUS[READY_BIT]) ready_d = 1'b0;
    if (wr_ctrl && !DBUS[OVERRUN_BIT]) overrun_d = 1'b0;
    if (wr_ctrl) ie_d = DBUS[IE_BIT];
    // A new key event outranks any clear issued in the same cycle.
    if (key_event) begin
      ready_d = 1'b1;
      if (ready_q && !rd_data) overrun_d = 1'b1;
    end

    data_word              = {{(BITS-NKEYS){1'b0}}, kdata_q};
    ctrl_word              = '0;
    ctrl_word[READY_BIT]   = ready_q;
    ctrl_word[OVERRUN_BIT] = overrun_q;
    ctrl_word[IE_BIT]      = ie_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      kdata_q   <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      kdata_q   <= kdata_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ie_q      <= ie_d;
    end
  end

  assign DBUS = rd_data ? data_word : (rd_ctrl ? ctrl_word : {BITS{1'bz}});
  assign INTR = ready_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_key_device.sv
`default_nettype none
//---- tb_key_device : directed scenarios plus randomized traffic against a behavioural model ----
//---- rev 1.0 ------------------------------------------------------------------------------------
module tb_key_device;

  localparam int          BITS   = 32;
  localparam logic [31:0] BASE   = 32'hF0000010;
  localparam int          DEB    = 4;
  localparam int          W      = DEB - 1;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] abus = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  key = 4'hF;
  logic        drv_en = 1'b0;
  logic [31:0] drv_val = 32'h0;
  wire         intr;
  wire  [31:0] dbus;

  assign dbus = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  key_device #(.BITS(BITS), .BASE(BASE), .DEB_CYC(DEB)) dut (
    .CLK   (clk),
    .reset (reset),
    .ABUS  (abus),
    .DBUS  (dbus),
    .WE    (we),
    .KEY   (key),
    .INTR  (intr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a key is accepted once its last W synchronised samples all
  // agree on a value different from the accepted one; KDATA shows it a cycle later.
  logic [3:0] m_s0, m_s1, m_acc, m_kd, m_samp, m_old_kd;
  logic [7:0] m_hist [4];
  logic       m_ready, m_ovr, m_ie, m_ev, m_rd, m_wr;

  always @(posedge clk) begin
    if (reset) begin
      m_s0 = 4'hF; m_s1 = 4'hF; m_acc = 4'h0; m_kd = 4'h0;
      m_ready = 1'b0; m_ovr = 1'b0; m_ie = 1'b0;
      for (int k = 0; k < 4; k++) m_hist[k] = 8'h0;
    end else begin
      m_old_kd = m_kd;
      m_kd     = m_acc;
      m_ev     = (m_kd != m_old_kd);
      m_samp   = ~m_s1;
      for (int k = 0; k < 4; k++) begin
        m_hist[k] = {m_hist[k][6:0], m_samp[k]};
        if ((m_hist[k][W-1:0] == {W{m_samp[k]}}) && (m_samp[k] != m_acc[k]))
          m_acc[k] = m_samp[k];
      end
      m_s1 = m_s0;
      m_s0 = key;
      m_rd = !we && (abus == A_DATA);
      m_wr = we && (abus == A_CTRL);
      if (m_ev) begin
        if (m_ready && !m_rd) m_ovr = 1'b1;
        else if (m_wr && !dbus[2]) m_ovr = 1'b0;
        m_ready = 1'b1;
      end else begin
        if (m_rd || (m_wr && !dbus[0])) m_ready = 1'b0;
        if (m_wr && !dbus[2]) m_ovr = 1'b0;
      end
      if (m_wr) m_ie = dbus[8];
    end
  end

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    we = 1'b0; abus = a; drv_en = 1'b0;
    #1;
    d = dbus;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    we = 1'b1; abus = a; drv_en = 1'b1; drv_val = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; key = 4'hF; we = 1'b0; abus = 32'h0; drv_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int ones;
    do_reset();
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_kdata: got %h expected %h", d, 32'h0); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_kctrl: got %h expected %h", d, 32'h0); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", intr); end
    @(negedge clk); abus = 32'h0; #1;
    ones = 0;
    for (int b = 0; b < 32; b++) if (dbus[b] === 1'b1) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL reset_idle_bus: got %h expected undriven", dbus); end
  endtask

  task automatic test_press();
    logic [31:0] d;
    int lat, ones;
    do_reset();
    @(negedge clk); key = 4'hE; abus = A_CTRL; we = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (dbus[0] === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL press_latency: got %0d expected %0d", lat, 6); end
    @(negedge clk); abus = 32'h0; #1;
    ones = 0;
    for (int b = 0; b < 32; b++) if (dbus[b] === 1'b1) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL press_idle_bus: got %h expected undriven", dbus); end
    @(negedge clk); we = 1'b1; abus = A_DATA; #1;
    ones = 0;
    for (int b = 0; b < 32; b++) if (dbus[b] === 1'b1) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL press_write_bus: got %h expected undriven", dbus); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL press_kdata: got %h expected %h", d, 32'h1); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL press_kctrl_after_read: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    int early, lat;
    do_reset();
    @(negedge clk); abus = A_CTRL; we = 1'b0;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c % 2 == 0) key[1] = ~key[1];
      #1;
      if (dbus[0] === 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL bounce_no_event: got %0d ready cycles expected 0", early); end
    @(negedge clk); key[1] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (dbus[0] === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL bounce_latency: got %0d expected %0d", lat, 6); end
    repeat (4) @(negedge clk);
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL bounce_kdata: got %h expected %h", d, 32'h2); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL bounce_single_event: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int lat;
    do_reset();
    bus_write(A_CTRL, 32'h100);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL irq_ie_set: got %h expected %h", d, 32'h100); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL irq_idle_intr: got %b expected 0", intr); end
    @(negedge clk); key = 4'hE;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (intr === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL irq_raise: got %0d cycles expected %0d", lat, 6); end
    @(negedge clk); key = 4'hC;
    repeat (10) @(negedge clk);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h105) begin errors++; $display("FAIL irq_overrun: got %h expected %h", d, 32'h105); end
    bus_write(A_CTRL, 32'h100);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL irq_clear: got %h expected %h", d, 32'h100); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", intr); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset();
    @(negedge clk); key = 4'hE; abus = A_CTRL; we = 1'b0;
    repeat (8) @(negedge clk);
    key = 4'hC;
    repeat (4) @(negedge clk);
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL coll_kdata_old: got %h expected %h", d, 32'h1); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL coll_kctrl: got %h expected %h", d, 32'h1); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL coll_kdata_new: got %h expected %h", d, 32'h3); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat;
    do_reset();
    @(negedge clk); key = 4'hE; abus = A_CTRL; we = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; abus = A_DATA; #1;
    checks++; if (dbus !== 32'h0) begin errors++; $display("FAIL midrst_kdata: got %h expected %h", dbus, 32'h0); end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); abus = A_CTRL; #1;
      if (i == 1) begin
        checks++; if (dbus !== 32'h0) begin errors++; $display("FAIL midrst_kctrl: got %h expected %h", dbus, 32'h0); end
      end
      if (dbus[0] === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL midrst_restart: got %0d expected %0d", lat, 6); end
  endtask

  task automatic test_random();
    int op, ones, idx;
    logic [31:0] exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 3);
        key[idx] = ~key[idx];
      end
      op = $urandom_range(0, 9);
      we = 1'b0; abus = 32'h0; drv_en = 1'b0;
      case (op)
        4: abus = A_DATA;
        5: abus = A_CTRL;
        6: begin we = 1'b1; abus = A_CTRL; drv_en = 1'b1; drv_val = $urandom; end
        7: begin we = 1'b1; abus = A_DATA; drv_en = 1'b1; drv_val = $urandom; end
        8: abus = A_DATA + 32'd8;
        default: ;
      endcase
      #1;
      checks++;
      if (intr !== (m_ready & m_ie)) begin
        errors++; $display("FAIL rand_intr cyc %0d: got %b expected %b", c, intr, m_ready & m_ie);
      end
      if (op == 4) begin
        exp = {28'h0, m_kd};
        checks++; if (dbus !== exp) begin errors++; $display("FAIL rand_kdata cyc %0d: got %h expected %h", c, dbus, exp); end
      end else if (op == 5) begin
        exp = 32'h0; exp[0] = m_ready; exp[2] = m_ovr; exp[8] = m_ie;
        checks++; if (dbus !== exp) begin errors++; $display("FAIL rand_kctrl cyc %0d: got %h expected %h", c, dbus, exp); end
      end else if (op != 6 && op != 7) begin
        ones = 0;
        for (int b = 0; b < 32; b++) if (dbus[b] === 1'b1) ones++;
        checks++; if (ones != 0) begin errors++; $display("FAIL rand_idle_bus cyc %0d: got %h expected undriven", c, dbus); end
      end
    end
    @(negedge clk); we = 1'b0; abus = 32'h0; drv_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_irq();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
